// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch controller and its PC selector.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    localparam logic [3:0]  EXC_CAUSE_IFETCH_TIMEOUT = 4'hE;
    localparam logic [63:0] DEFAULT_RESET_PC         = 64'h0;
    localparam logic [63:0] DEFAULT_EXC_VECTOR       = 64'hD8;

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC priority select: exception vector > ERET (elr) > branch target > sequential.
module fetch_pc_sel
    import fetch_ctrl_pkg::*;
#(
    parameter int             N          = 64,
    parameter logic [N-1:0]   EXC_VECTOR = N'(DEFAULT_EXC_VECTOR)
) (
    input  logic         exc_req,
    input  logic         exc_return,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    input  logic [N-1:0] elr,
    input  logic [N-1:0] seq_pc,
    output logic         redirect,
    output logic [N-1:0] next_pc
);

    always_comb begin
        redirect = 1'b1;
        next_pc  = seq_pc;
        if (exc_req) begin
            next_pc = EXC_VECTOR;
        end else if (exc_return) begin
            next_pc = elr;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end else begin
            redirect = 1'b0;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: PC register, imem request/ack handshake, one-entry
// instruction buffer and ELR/ESR. Optional ack watchdog: FETCH_CTRL_TIMEOUT_EN.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int           N          = 64,
    parameter logic [N-1:0] RESET_PC   = N'(DEFAULT_RESET_PC),
    parameter logic [N-1:0] EXC_VECTOR = N'(DEFAULT_EXC_VECTOR),
    parameter int           TIMEOUT    = 16
) (
    input  logic         clk,
    input  logic         reset,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [31:0]  imem_rdata,
    output logic         instr_valid,
    output logic [31:0]  instr,
    output logic [N-1:0] instr_pc,
    input  logic         instr_ready,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    input  logic         exc_req,
    input  logic [3:0]   exc_cause,
    input  logic [N-1:0] exc_pc,
    input  logic         exc_return,
    output logic [N-1:0] elr,
    output logic [3:0]   esr
);

    state_e       state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic [N-1:0] pend_q, pend_d;
    logic         squash_q, squash_d;
    logic         valid_q, valid_d;
    logic [31:0]  instr_q, instr_d;
    logic [N-1:0] instr_pc_q, instr_pc_d;
    logic [N-1:0] elr_q, elr_d;
    logic [3:0]   esr_q, esr_d;
    logic         redirect;
    logic [N-1:0] next_pc;

    fetch_pc_sel #(
        .N          (N),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_pc_sel (
        .exc_req       (exc_req),
        .exc_return    (exc_return),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .elr           (elr_q),
        .seq_pc        (pc_q + N'(4)),
        .redirect      (redirect),
        .next_pc       (next_pc)
    );

`ifdef FETCH_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        squash_d   = squash_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        elr_d      = elr_q;
        esr_d      = esr_q;

        if (exc_req) begin
            elr_d = exc_pc;
            esr_d = exc_cause;
        end

        case (state_q)
            ST_START: begin
                valid_d = 1'b0;
                state_d = ST_REQ;
                if (redirect) pc_d = next_pc;
            end
            ST_REQ: begin
                if (imem_ack) begin
                    squash_d = 1'b0;
                    if (redirect) begin
                        pc_d = next_pc;
                    end else if (squash_q) begin
                        pc_d = pend_q;
                    end else begin
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                        state_d    = ST_HOLD;
                    end
                end else if (redirect) begin
                    // Address must stay stable until ack; remember where to go.
                    pend_d   = next_pc;
                    squash_d = 1'b1;
                end
            end
            ST_HOLD: begin
                // next_pc is the redirect target when present, else pc+4.
                if (redirect || (valid_q && instr_ready)) begin
                    valid_d = 1'b0;
                    pc_d    = next_pc;
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_START;
        endcase

`ifdef FETCH_CTRL_TIMEOUT_EN
        tmo_cnt_d = '0;
        if (state_q == ST_REQ && !imem_ack) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
            if (tmo_cnt_q == TW'(TIMEOUT - 1) && !exc_req) begin
                elr_d     = pc_q;
                esr_d     = EXC_CAUSE_IFETCH_TIMEOUT;
                pc_d      = EXC_VECTOR;
                squash_d  = 1'b0;
                state_d   = ST_START;
                tmo_cnt_d = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_START;
            pc_q       <= RESET_PC;
            pend_q     <= '0;
            squash_q   <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            elr_q      <= '0;
            esr_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            squash_q   <= squash_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            elr_q      <= elr_d;
            esr_q      <= esr_d;
        end
    end

`ifdef FETCH_CTRL_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset) tmo_cnt_q <= '0;
        else        tmo_cnt_q <= tmo_cnt_d;
    end
`endif

    assign imem_req    = (state_q == ST_REQ);
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign elr         = elr_q;
    assign esr         = esr_q;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the fetch stage of the exception-capable ARM core.
- Owns the PC register and the instruction-memory request/ack handshake.
- Selects next PC by priority: exception vector, ERET return, branch target, PC+4.
- Holds one fetched instruction in an output buffer until decode accepts it.
- Keeps ELR/ESR for the exception path.

Parameters:
- N, 64, address/PC width
- RESET_PC, 64'h0, first fetch address after reset
- EXC_VECTOR, 64'hD8, exception entry address
- TIMEOUT, 16, ack watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-low reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  N  fetch address (the PC)
- imem_ack  in  1  memory response valid
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- instr_valid  out  1  buffered instruction available to decode
- instr  out  32  buffered instruction
- instr_pc  out  N  PC of buffered instruction
- instr_ready  in  1  decode accepts the buffered instruction
- branch_taken  in  1  redirect to branch_target
- branch_target  in  N  branch destination
- exc_req  in  1  take exception
- exc_cause  in  4  exception cause code
- exc_pc  in  N  PC of faulting instruction
- exc_return  in  1  ERET: redirect to elr
- elr  out  N  exception link register
- esr  out  4  exception syndrome (cause)

Behaviour:
- Reset: sampled on posedge clk while reset=0. Outputs after reset: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, elr=0, esr=0. State goes to START.
- States:
  - START: one idle cycle, then REQ.
  - REQ: imem_req=1 with imem_addr=pc. Both stay stable until imem_ack=1 (ack may arrive in the same cycle as req).
  - On ack in REQ: capture imem_rdata and pc into the buffer. instr_valid=1 from the next cycle. Go to HOLD.
  - HOLD: imem_req=0. When instr_valid and instr_ready are both 1, clear instr_valid, set pc<=pc+4 (modulo 2^N), go to REQ.
- Throughput: at most one instruction every 2 cycles. First fetch: imem_req=1 two cycles after reset release.
- Redirects: priority is exc_req > exc_return > branch_taken.
  - exc_req: next pc=EXC_VECTOR; elr<=exc_pc; esr<=exc_cause.
  - exc_return: next pc=elr.
  - branch_taken: next pc=branch_target.
- Redirect in HOLD or START: buffer dropped (instr_valid=0 next cycle), pc<=target, go to REQ.
- Redirect in REQ without ack in the same cycle:
  - pc target stored in a pending register and the squash flag set.
  - imem_addr stays unchanged until ack.
  - The ack data is discarded, then REQ restarts at the target.
  - Later redirects while squash is set overwrite the pending target (same priority).
- Redirect in REQ in the same cycle as ack: data discarded, pc<=target, stay in REQ with a new address next cycle.
- Redirect in the same cycle as instr_ready in HOLD: the handshake completes; redirect target wins over pc+4.
- Reset mid-transaction: outstanding request abandoned. Any later stray ack while not in REQ is ignored.
- elr/esr change only on exc_req.

Optional Feature:
- Macro: FETCH_CTRL_TIMEOUT_EN.
- Defined:
  - A cycle counter runs while in REQ and clears on ack or on leaving REQ.
  - When the counter reaches TIMEOUT without ack, the block raises an internal exception: elr<=pc, esr<=4'hE, pc<=EXC_VECTOR. It then drops req for 1 cycle and re-enters REQ.
  - An external exc_req in the same cycle wins.
- Undefined: no counter; REQ waits for ack indefinitely.

Decomposition:
- Package fetch_ctrl_pkg holds:
  - state enum (START, REQ, HOLD)
  - cause constant EXC_CAUSE_IFETCH_TIMEOUT=4'hE
  - default RESET_PC and EXC_VECTOR localparams
- Sub-module fetch_pc_sel: combinational next-PC priority select (exc/eret/branch/seq), instantiated once.

Test Plan:
- Reset release, ack 1 cycle after each req, instr_ready=1 → imem_addr sequence 0x0, 0x4, 0x8; instr_pc matches; first req 2 cycles after reset release.
- instr_ready held 0 for 5 cycles in HOLD → instr_valid stays 1, imem_req=0, pc unchanged; ready=1 → next req at pc+4.
- branch_taken to 0x100 in REQ, ack 3 cycles later → ack data not presented (instr_valid stays 0), next req at 0x100.
- exc_req (cause 4'h3, exc_pc=0x40) together with branch_taken → elr=0x40, esr=3, next req at 0xD8. Then exc_return → req at 0x40.
- reset=0 asserted while in REQ awaiting ack → all outputs at reset values next cycle; a late ack is ignored.
- With FETCH_CTRL_TIMEOUT_EN and TIMEOUT=16, ack never asserted → after 16 REQ cycles esr=4'hE, elr=stalled pc, req reissued at 0xD8.
